// File: rtl/sprite_row_drawer.sv
// Sprite row serializer: once per scanline, picks the glyph row for the beam and
// shifts it out across the sprite's span, with optional integer pixel replication.
module sprite_row_drawer #(
  parameter int SCALE    = 1,
  parameter int H_ACTIVE = 640
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_ce,
  input  logic        en,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic [9:0]  spr_x,
  input  logic [9:0]  spr_y,
  output logic [3:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic        pixel_on,
  output logic        busy
);

  localparam int         SH       = (SCALE == 4) ? 2 : (SCALE == 2) ? 1 : 0;
  localparam logic [1:0] REP_LAST = 2'(SCALE - 1);
  localparam logic [9:0] SPAN     = 10'(16 * SCALE);
  localparam logic [9:0] H_LIMIT  = 10'(H_ACTIVE);

  generate
    if (SCALE != 1 && SCALE != 2 && SCALE != 4) begin : g_bad_scale
      $error("sprite_row_drawer: SCALE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  rom_addr_q, rom_addr_d;
  logic        pixel_on_q, pixel_on_d;
  logic        row_hit_q, row_hit_d;
  logic [9:0]  x_lat_q, x_lat_d;
  logic [15:0] shreg_q, shreg_d;
  logic [3:0]  col_q, col_d;
  logic [1:0]  rep_q, rep_d;
  logic        fix_q, fix_d;

  logic        line_start;
  logic [9:0]  dy;
  logic        hit_now;
  logic [15:0] shreg_eff;

  assign line_start = (hcount == 10'd0);
  assign dy         = vcount - spr_y;
  assign hit_now    = en && (vcount >= spr_y) && (dy < SPAN);
  // A DRAW entered at line start loaded a stale row; the fresh ROM word replaces it one clk later.
  assign shreg_eff  = fix_q ? rom_data : shreg_q;

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    pixel_on_d = pixel_on_q;
    row_hit_d  = row_hit_q;
    x_lat_d    = x_lat_q;
    shreg_d    = shreg_q;
    col_d      = col_q;
    rep_d      = rep_q;
    fix_d      = 1'b0;

    if (fix_q && !pix_ce) begin
      shreg_d = rom_data;
      if (state_q == DRAW) pixel_on_d = rom_data[15];
    end

    if (pix_ce) begin
      pixel_on_d = 1'b0;
      shreg_d    = shreg_eff;
      if (line_start) begin
        x_lat_d    = spr_x;
        row_hit_d  = hit_now;
        rom_addr_d = 4'(dy >> SH);
        state_d    = IDLE;
      end

      if (!en) begin
        state_d   = IDLE;
        row_hit_d = 1'b0;
      end else begin
        if (state_q == DRAW && !line_start) begin
          if (rep_q == REP_LAST) begin
            if (col_q == 4'd15) begin
              state_d = DONE;
            end else begin
              shreg_d    = {shreg_eff[14:0], 1'b0};
              col_d      = col_q + 4'd1;
              rep_d      = 2'd0;
              pixel_on_d = shreg_eff[14];
            end
          end else begin
            rep_d      = rep_q + 2'd1;
            pixel_on_d = shreg_eff[15];
          end
        end

        if ((state_q == IDLE || line_start) && row_hit_d && hcount == x_lat_d) begin
          state_d = DRAW;
          shreg_d = rom_data;
          rep_d   = 2'd0;
          col_d   = 4'd0;
          if (line_start) fix_d = 1'b1;
          else            pixel_on_d = rom_data[15];
        end
      end

      if (hcount >= H_LIMIT) pixel_on_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rom_addr_q <= 4'd0;
      pixel_on_q <= 1'b0;
      row_hit_q  <= 1'b0;
      x_lat_q    <= 10'd0;
      shreg_q    <= 16'd0;
      col_q      <= 4'd0;
      rep_q      <= 2'd0;
      fix_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      pixel_on_q <= pixel_on_d;
      row_hit_q  <= row_hit_d;
      x_lat_q    <= x_lat_d;
      shreg_q    <= shreg_d;
      col_q      <= col_d;
      rep_q      <= rep_d;
      fix_q      <= fix_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign pixel_on = pixel_on_q;
  assign busy     = (state_q == DRAW);

endmodule

// File: tb/tb_sprite_row_drawer.sv
// Bench for sprite_row_drawer: SCALE=1 and SCALE=2 instances share stimulus and
// are compared against a per-line arithmetic model of the sprite span.
module tb_sprite_row_drawer;

  localparam int HTOT = 720;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pix_ce = 1'b0;
  logic       en = 1'b0;
  logic [9:0] hcount = '0, vcount = '0, spr_x = '0, spr_y = '0;
  logic [3:0] addr1, addr2;
  logic [15:0] data1, data2;
  logic       pon1, pon2, busy1, busy2;
  logic [1:0] pon_v, busy_v;
  logic [3:0] addr_v [2];
  logic [15:0] rom [16];

  assign data1  = rom[addr1];
  assign data2  = rom[addr2];
  assign pon_v  = {pon2, pon1};
  assign busy_v = {busy2, busy1};
  assign addr_v[0] = addr1;
  assign addr_v[1] = addr2;

  always #5 clk = ~clk;

  sprite_row_drawer #(.SCALE(1), .H_ACTIVE(640)) u_s1 (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .en(en), .hcount(hcount), .vcount(vcount),
    .spr_x(spr_x), .spr_y(spr_y), .rom_addr(addr1), .rom_data(data1), .pixel_on(pon1), .busy(busy1));

  sprite_row_drawer #(.SCALE(2), .H_ACTIVE(640)) u_s2 (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .en(en), .hcount(hcount), .vcount(vcount),
    .spr_x(spr_x), .spr_y(spr_y), .rom_addr(addr2), .rom_data(data2), .pixel_on(pon2), .busy(busy2));

  int checks = 0;
  int errors = 0;

  int scl [2] = '{1, 2};
  int m_x [2];
  int m_row [2];
  bit m_hit [2];
  bit m_ok = 1'b0;
  bit exp_p [2];
  bit exp_b [2];

  // Reference: at line start latch position and decide the row; a pixel is lit
  // when the beam is k columns into the span and glyph bit 15-k/S is set.
  task automatic drive_pixel(input int h);
    int dy, k;
    hcount = 10'(h);
    pix_ce = 1'b1;
    if (h == 0) begin
      m_ok = en;
      for (int i = 0; i < 2; i++) begin
        dy       = int'(vcount) - int'(spr_y);
        m_hit[i] = en && dy >= 0 && dy < 16 * scl[i];
        m_row[i] = m_hit[i] ? dy / scl[i] : 0;
        m_x[i]   = int'(spr_x);
      end
    end
    if (!en) m_ok = 1'b0;
    for (int i = 0; i < 2; i++) begin
      k        = h - m_x[i];
      exp_b[i] = m_ok && m_hit[i] && k >= 0 && k < 16 * scl[i];
      exp_p[i] = 1'b0;
      if (exp_b[i] && h < 640) exp_p[i] = rom[m_row[i]][15 - k / scl[i]];
    end
    @(posedge clk);
    #1 pix_ce = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int vc, input int sx, input int sy);
    vcount = 10'(vc);
    spr_x  = 10'(sx);
    spr_y  = 10'(sy);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (pon_v[i] !== 1'b0 || busy_v[i] !== 1'b0 || addr_v[i] !== 4'd0) begin
        errors++;
        $display("FAIL reset s%0d got pon=%b busy=%b addr=%0d want 0/0/0", scl[i], pon_v[i], busy_v[i], addr_v[i]);
      end
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_plan_rows;
    int on_cnt, busy_cnt;
    for (int r = 0; r < 16; r++) rom[r] = 16'($urandom);
    rom[2] = 16'h03C0;
    en = 1'b1;
    for (int ln = 0; ln < 2; ln++) begin
      set_line(ln == 0 ? 52 : 54, 100, 50);
      on_cnt = 0;
      busy_cnt = 0;
      for (int h = 0; h < HTOT; h++) begin
        drive_pixel(h);
        for (int i = 0; i < 2; i++) begin
          checks++;
          if (pon_v[i] !== exp_p[i]) begin
            errors++;
            $display("FAIL plan_pixel s%0d h=%0d got %b want %b", scl[i], h, pon_v[i], exp_p[i]);
          end
          checks++;
          if (busy_v[i] !== exp_b[i]) begin
            errors++;
            $display("FAIL plan_busy s%0d h=%0d got %b want %b", scl[i], h, busy_v[i], exp_b[i]);
          end
        end
        if (ln == 0 && pon1 === 1'b1) on_cnt++;
        if (ln == 0 && busy1 === 1'b1) busy_cnt++;
        if (ln == 1 && pon2 === 1'b1) on_cnt++;
        if (ln == 1 && busy2 === 1'b1) busy_cnt++;
      end
      checks++;
      if ((ln == 0 ? addr1 : addr2) !== 4'd2) begin
        errors++;
        $display("FAIL plan_rom_addr line%0d got %0d want 2", ln, ln == 0 ? addr1 : addr2);
      end
      checks++;
      if (on_cnt != (ln == 0 ? 4 : 8) || busy_cnt != (ln == 0 ? 16 : 32)) begin
        errors++;
        $display("FAIL plan_counts line%0d got on=%0d busy=%0d want %0d/%0d", ln, on_cnt, busy_cnt,
                 ln == 0 ? 4 : 8, ln == 0 ? 16 : 32);
      end
    end
  endtask

  task automatic test_vertical_bounds;
    int vcs [3] = '{49, 66, 10};
    int sys [3] = '{50, 50, 1000};
    for (int r = 0; r < 16; r++) rom[r] = 16'hFFFF;
    en = 1'b1;
    for (int ln = 0; ln < 3; ln++) begin
      set_line(vcs[ln], 100, sys[ln]);
      for (int h = 0; h < HTOT; h++) begin
        drive_pixel(h);
        for (int i = 0; i < 2; i++) begin
          checks++;
          if (pon_v[i] !== exp_p[i] || busy_v[i] !== exp_b[i]) begin
            errors++;
            $display("FAIL vbound s%0d v=%0d h=%0d got pon=%b busy=%b want %b/%b",
                     scl[i], vcs[ln], h, pon_v[i], busy_v[i], exp_p[i], exp_b[i]);
          end
        end
      end
    end
  endtask

  task automatic test_clip;
    int last_lit;
    for (int r = 0; r < 16; r++) rom[r] = 16'hFFFF;
    en = 1'b1;
    for (int ln = 0; ln < 2; ln++) begin
      if (ln == 0) set_line(52, 632, 50);
      else         set_line(300, 632, 50);
      last_lit = -1;
      for (int h = 0; h < HTOT; h++) begin
        drive_pixel(h);
        if (pon1 === 1'b1) last_lit = h;
        for (int i = 0; i < 2; i++) begin
          checks++;
          if (pon_v[i] !== exp_p[i] || busy_v[i] !== exp_b[i]) begin
            errors++;
            $display("FAIL clip s%0d line%0d h=%0d got pon=%b busy=%b want %b/%b",
                     scl[i], ln, h, pon_v[i], busy_v[i], exp_p[i], exp_b[i]);
          end
        end
      end
      checks++;
      if (last_lit != (ln == 0 ? 639 : -1)) begin
        errors++;
        $display("FAIL clip_last line%0d got %0d want %0d", ln, last_lit, ln == 0 ? 639 : -1);
      end
    end
  endtask

  task automatic test_en_drop;
    for (int r = 0; r < 16; r++) rom[r] = 16'hFFFF;
    en = 1'b1;
    set_line(52, 100, 50);
    for (int h = 0; h < HTOT; h++) begin
      en = (h == 105) ? 1'b0 : 1'b1;
      drive_pixel(h);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (pon_v[i] !== exp_p[i] || busy_v[i] !== exp_b[i]) begin
          errors++;
          $display("FAIL en_drop s%0d h=%0d got pon=%b busy=%b want %b/%b",
                   scl[i], h, pon_v[i], busy_v[i], exp_p[i], exp_b[i]);
        end
      end
    end
    en = 1'b1;
  endtask

  task automatic test_reset_mid_draw;
    for (int r = 0; r < 16; r++) rom[r] = 16'($urandom);
    rom[2] = 16'h03C0;
    rom[1] = 16'hFFFF;
    en = 1'b1;
    set_line(52, 100, 50);
    for (int h = 0; h < 108; h++) drive_pixel(h);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (pon_v[i] !== 1'b0 || busy_v[i] !== 1'b0 || addr_v[i] !== 4'd0) begin
        errors++;
        $display("FAIL async_reset s%0d got pon=%b busy=%b addr=%0d want 0/0/0", scl[i], pon_v[i], busy_v[i], addr_v[i]);
      end
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_ok = 1'b0;
    for (int ln = 0; ln < 2; ln++) begin
      if (ln == 1) set_line(52, 100, 50);
      for (int h = (ln == 0 ? 108 : 0); h < HTOT; h++) begin
        drive_pixel(h);
        for (int i = 0; i < 2; i++) begin
          checks++;
          if (pon_v[i] !== exp_p[i] || busy_v[i] !== exp_b[i]) begin
            errors++;
            $display("FAIL after_reset s%0d line%0d h=%0d got pon=%b busy=%b want %b/%b",
                     scl[i], ln, h, pon_v[i], busy_v[i], exp_p[i], exp_b[i]);
          end
        end
        if (ln == 1 && h == 107) begin
          repeat (6) @(posedge clk);
          #1;
          for (int i = 0; i < 2; i++) begin
            checks++;
            if (pon_v[i] !== exp_p[i] || busy_v[i] !== exp_b[i]) begin
              errors++;
              $display("FAIL ce_hold s%0d got pon=%b busy=%b want %b/%b",
                       scl[i], pon_v[i], busy_v[i], exp_p[i], exp_b[i]);
            end
          end
        end
      end
    end
  endtask

  task automatic test_random;
    int drop_h, vc, sx;
    for (int ln = 0; ln < 6; ln++) begin
      for (int r = 0; r < 16; r++) rom[r] = 16'($urandom);
      vc     = $urandom_range(0, 1023);
      sx     = (ln == 0) ? 0 : $urandom_range(0, 680);
      drop_h = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 700) : -1;
      set_line(vc, sx, (vc - $urandom_range(0, 40)) & 10'h3FF);
      en = 1'b1;
      for (int h = 0; h < HTOT; h++) begin
        if (h == drop_h) en = 1'b0;
        if (h == drop_h + 3) en = 1'b1;
        drive_pixel(h);
        for (int i = 0; i < 2; i++) begin
          checks++;
          if (pon_v[i] !== exp_p[i] || busy_v[i] !== exp_b[i]) begin
            errors++;
            $display("FAIL random s%0d line%0d h=%0d got pon=%b busy=%b want %b/%b",
                     scl[i], ln, h, pon_v[i], busy_v[i], exp_p[i], exp_b[i]);
          end
          if (h == 1 && m_hit[i]) begin
            checks++;
            if (addr_v[i] !== 4'(m_row[i])) begin
              errors++;
              $display("FAIL random_addr s%0d line%0d got %0d want %0d", scl[i], ln, addr_v[i], m_row[i]);
            end
          end
        end
      end
    end
  endtask

  initial begin
    for (int r = 0; r < 16; r++) rom[r] = 16'h0000;
    #1;
    test_reset;
    test_plan_rows;
    test_vertical_bounds;
    test_clip;
    test_en_drop;
    test_reset_mid_draw;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_row_drawer.md
Name: sprite_row_drawer

Overview:
- Pixel-pipeline stage that consumes 16x16 sprite glyph rows from the sprite ROM and produces a per-pixel on/off stream for the VGA colour mux.
- The ROM is combinational: it takes a 4-bit row address and returns a 16-bit row, with bit 15 as the leftmost pixel.
- Once per scanline, this block computes the ROM row address from the beam position and a latched sprite position. It then serializes the returned row across the sprite's horizontal span, with optional integer pixel replication (scaling).

Parameters:
- SCALE, 1, pixel replication factor in both axes. Legal values are 1, 2 and 4; any other value is a synthesis error.
- H_ACTIVE, 640, first non-visible hcount. pixel_on is forced to 0 at and beyond this value.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- pix_ce  in  1  pixel clock enable, one clk wide per pixel. All state advances only when pix_ce=1.
- en  in  1  sprite enable.
- hcount  in  10  current beam column.
- vcount  in  10  current beam row.
- spr_x  in  10  sprite left column. Sampled at line start.
- spr_y  in  10  sprite top row. Sampled at line start.
- rom_addr  out  4  row address driven to the sprite ROM.
- rom_data  in  16  row bits returned by the ROM, combinational from rom_addr.
- pixel_on  out  1  registered sprite-pixel flag for the hcount presented on the previous pix_ce.
- busy  out  1  high while in the DRAW state.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - rst_n low asynchronously forces: state=IDLE, rom_addr=0, pixel_on=0, busy=0, row_hit=0, x_lat=0, y_lat=0, shift register=0, col_cnt=0, rep_cnt=0.
- Line start (pix_ce and hcount==0):
  - x_lat<=spr_x.
  - Compute dy=vcount-spr_y, 10-bit unsigned.
  - row_hit<=en && (vcount>=spr_y) && (dy<16*SCALE).
  - rom_addr<=dy>>log2(SCALE), truncated to 4 bits.
  - rom_addr therefore stays stable for the whole line, and rom_data is valid from the next clk onward.
  - Line start also forces state to IDLE, aborting any DRAW that ran past the end of the line. Such a sprite is clipped, not wrapped.
- States: IDLE, DRAW, DONE.
  - IDLE -> DRAW on pix_ce && row_hit && hcount==x_lat: shreg<=rom_data, rep_cnt<=0, col_cnt<=0.
  - DRAW, on each pix_ce:
    - rep_cnt increments.
    - When rep_cnt==SCALE-1: shreg shifts left by 1, rep_cnt<=0, col_cnt++.
    - When col_cnt==15 and rep_cnt==SCALE-1: go to DONE.
  - DONE holds until the next line start, then goes to IDLE.
- Output timing:
  - Latency is 1 pix_ce. For the pix_ce where hcount=x_lat+k, with 0<=k<16*SCALE, pixel_on on the following clk equals rom_data[15-k/SCALE].
  - pixel_on is 0 for every other hcount, and whenever hcount>=H_ACTIVE at the sampling pix_ce.
  - pixel_on holds its value between pix_ce pulses.
- busy=1 exactly while state==DRAW.
- en deasserted mid-line: pixel_on<=0 on the next pix_ce and state goes to IDLE. Redraw starts no earlier than the next line start, and only if en=1 then.
- spr_x and spr_y changes mid-line have no effect until the next line start.
- vcount<spr_y: row_hit=0. The unsigned wrap of dy must not produce a hit.
- x_lat=0: the IDLE->DRAW match occurs at the same pix_ce as line start. Both line start and the DRAW entry take effect, so column 0 is drawn.
- Reset asserted mid-DRAW: outputs are 0 immediately. After release, the block resumes at the next line start.

Test Plan:
- SCALE=1, en=1, spr_x=100, spr_y=50, vcount=52, ROM row 2=0x03C0:
  - rom_addr=2 after line start.
  - pixel_on=1 exactly for hcount 106..109, observed one pix_ce later.
  - busy=1 for hcount 100..115.
- SCALE=2, spr_x=100, spr_y=50, vcount=54:
  - rom_addr=2.
  - pixel_on=1 for hcount 112..119.
  - busy=1 for hcount 100..131.
- Vertical bounds:
  - vcount=49 or vcount=66 with spr_y=50, SCALE=1: row_hit=0 and pixel_on stays 0 all line.
  - spr_y=1000, vcount=10: no hit, checking the dy wrap.
- Horizontal clip: spr_x=632, SCALE=1, ROM row=0xFFFF:
  - pixel_on=1 for hcount 632..639, and 0 from 640 onward.
  - Line start at hcount=0 returns state to IDLE with no column carried into the next line.
- en dropped at hcount=105 during a 0xFFFF row: pixel_on=0 from the next pix_ce, busy=0, and the row does not resume on that line.
- rst_n pulsed low at hcount=108 mid-DRAW:
  - pixel_on, busy and rom_addr go to 0 asynchronously.
  - After release, drawing resumes correctly on the following line.
  - pix_ce held low for several clk: no state change and outputs held.
